// File: rtl/irq_conditioner.sv
// Interrupt front-end for CP0: synchronizes six external request lines, conditions each
// as level or edge, ORs a compare timer onto one line, and exposes a 4-word register window.
module irq_conditioner #(
    parameter int unsigned TIMER_LINE  = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq_in,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [5:0]  interrupt
);

    typedef enum logic [1:0] {
        REG_MODE    = 2'd0,
        REG_PEND    = 2'd1,
        REG_COMPARE = 2'd2,
        REG_COUNT   = 2'd3
    } reg_sel_e;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]  sync, sync_d;
    logic [5:0]  mode_edge, pend, pend_n, int_n;
    logic [5:0]  rise, mode_chg, w1c;
    logic        timer_en, tpend, tpend_n, match;
    logic [31:0] count, compare;
    logic        wr_mode, wr_pend, wr_compare, wr_count;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        wr_mode    = we && (reg_sel_e'(addr) == REG_MODE);
        wr_pend    = we && (reg_sel_e'(addr) == REG_PEND);
        wr_compare = we && (reg_sel_e'(addr) == REG_COMPARE);
        wr_count   = we && (reg_sel_e'(addr) == REG_COUNT);

        rise     = sync & ~sync_d;
        mode_chg = wr_mode ? (wd[5:0] ^ mode_edge) : '0;
        w1c      = wr_pend ? (wd[5:0] & mode_edge) : '0;

        // A mode change wipes the line outright; otherwise an edge set beats a same-cycle W1C.
        pend_n = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (mode_chg[i])
                pend_n[i] = 1'b0;
            else if (!mode_edge[i])
                pend_n[i] = sync[i];
            else
                pend_n[i] = rise[i] | (pend[i] & ~w1c[i]);
        end

        match = timer_en && (count == compare);
        if (wr_compare || (wr_pend && wd[TIMER_LINE]))
            tpend_n = 1'b0;
        else if (match)
            tpend_n = 1'b1;
        else
            tpend_n = tpend;

        int_n             = pend_n;
        int_n[TIMER_LINE] = pend_n[TIMER_LINE] | tpend_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= '0;
            sync_d    <= '0;
            pend      <= '0;
            tpend     <= 1'b0;
            interrupt <= '0;
            mode_edge <= '0;
            timer_en  <= 1'b0;
            count     <= '0;
            compare   <= '1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
            sync_d    <= sync;
            pend      <= pend_n;
            tpend     <= tpend_n;
            interrupt <= int_n;
            if (wr_mode) begin
                mode_edge <= wd[5:0];
                timer_en  <= wd[8];
            end
            if (wr_compare)
                compare <= wd;
            if (wr_count)
                count <= wd;
            else if (timer_en)
                count <= count + 32'd1;
        end
    end

    always_comb begin
        rd = '0;
        unique case (reg_sel_e'(addr))
            REG_MODE:    rd = {23'b0, timer_en, 2'b0, mode_edge};
            REG_PEND:    rd = {18'b0, sync, 2'b0, interrupt};
            REG_COMPARE: rd = compare;
            REG_COUNT:   rd = count;
        endcase
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: per-cycle vector table plus timer and reset sequences.
module tb_irq_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_in;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [5:0]  interrupt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  irq;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [5:0]  exp_int;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    irq_conditioner #(.TIMER_LINE(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr),
        .wd(wd), .rd(rd), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [5:0] i, input logic w,
                                input logic [1:0] a, input logic [31:0] d,
                                input logic [5:0] ei, input logic [31:0] er);
        vec_t v;
        v.rst = r; v.irq = i; v.we = w; v.addr = a; v.wd = d;
        v.exp_int = ei; v.exp_rd = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle on the falling edge, check both outputs just after the rising edge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        rst = v.rst; irq_in = v.irq; we = v.we; addr = v.addr; wd = v.wd;
        @(posedge clk);
        #1;
        chk({tag, "_int"}, {26'b0, interrupt}, {26'b0, v.exp_int});
        chk({tag, "_rd"}, rd, v.exp_rd);
    endtask

    initial begin
        rst = 1'b0; irq_in = '0; we = 1'b0; addr = '0; wd = '0;

        // reset and register readback
        vecs.push_back(mk(0, 6'h00, 0, 2'd0, 0, 6'h00, 32'h0));
        vecs.push_back(mk(1, 6'h00, 0, 2'd0, 0, 6'h00, 32'h0));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0));
        vecs.push_back(mk(1, 6'h00, 0, 2'd2, 0, 6'h00, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 6'h00, 0, 2'd3, 0, 6'h00, 32'h0));
        // level line 0: assert latency, ignored W1C, deassert latency
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h01, 1, 2'd1, 1, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h01, 32'h0001));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0000));
        // MODE=0x21, pulse line 5, hold, W1C
        vecs.push_back(mk(1, 6'h00, 1, 2'd0, 32'h21, 6'h00, 32'h0021));
        vecs.push_back(mk(1, 6'h20, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h20, 0, 2'd1, 0, 6'h00, 32'h2000));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h20, 32'h2020));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h20, 32'h0020));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h20, 32'h0020));
        vecs.push_back(mk(1, 6'h00, 1, 2'd1, 32'h20, 6'h00, 32'h0000));
        // edge line 0: set beats same-cycle W1C, plain W1C clears
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h01, 1, 2'd1, 1, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h01, 1, 2'd1, 1, 6'h00, 32'h0100));
        // fresh edge, then MODE=0 clears the pending line; it returns as level
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h01, 1, 2'd0, 32'h0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h0101));
        // level deassert, then an edge arriving with a mode change is dropped
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h01, 32'h0101));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h01, 32'h0001));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0000));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h01, 1, 2'd0, 32'h01, 6'h00, 32'h0001));
        vecs.push_back(mk(1, 6'h01, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0100));
        vecs.push_back(mk(1, 6'h00, 0, 2'd1, 0, 6'h00, 32'h0000));

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // timer: COUNT=0, COMPARE=10, enable; fires 11 edges after the enable write
        apply("t_count0", mk(1, 6'h00, 1, 2'd3, 32'h0, 6'h00, 32'h0));
        apply("t_cmp10",  mk(1, 6'h00, 1, 2'd2, 32'hA, 6'h00, 32'hA));
        apply("t_en",     mk(1, 6'h00, 1, 2'd0, 32'h100, 6'h00, 32'h100));
        for (int j = 1; j <= 12; j++)
            apply($sformatf("t_run%0d", j),
                  mk(1, 6'h00, 0, 2'd3, 0, (j >= 11) ? 6'h20 : 6'h00, 32'(j)));
        apply("t_cmpclr", mk(1, 6'h00, 1, 2'd2, 32'h1, 6'h00, 32'h1));
        apply("t_ld",     mk(1, 6'h00, 1, 2'd3, 32'hFFFF_FFFE, 6'h00, 32'hFFFF_FFFE));
        apply("t_w1",     mk(1, 6'h00, 0, 2'd3, 0, 6'h00, 32'hFFFF_FFFF));
        apply("t_w2",     mk(1, 6'h00, 0, 2'd3, 0, 6'h00, 32'h0));
        apply("t_w3",     mk(1, 6'h00, 0, 2'd3, 0, 6'h00, 32'h1));
        apply("t_w4",     mk(1, 6'h00, 0, 2'd3, 0, 6'h20, 32'h2));
        apply("t_hold",   mk(1, 6'h00, 0, 2'd3, 0, 6'h20, 32'h3));
        apply("t_w1c",    mk(1, 6'h00, 1, 2'd1, 32'h20, 6'h00, 32'h0));
        apply("t_off",    mk(1, 6'h00, 1, 2'd0, 32'h20, 6'h00, 32'h20));

        // reset while line 0 (level) and line 5 (edge) are both asserted and sources held
        apply("r_a1", mk(1, 6'h21, 0, 2'd1, 0, 6'h00, 32'h0000));
        apply("r_a2", mk(1, 6'h21, 0, 2'd1, 0, 6'h00, 32'h2100));
        apply("r_a3", mk(1, 6'h21, 0, 2'd1, 0, 6'h21, 32'h2121));
        apply("r_rst", mk(0, 6'h21, 0, 2'd0, 0, 6'h00, 32'h0));
        apply("r_e1", mk(1, 6'h21, 0, 2'd2, 0, 6'h00, 32'hFFFF_FFFF));
        apply("r_e2", mk(1, 6'h21, 0, 2'd3, 0, 6'h00, 32'h0));
        apply("r_e3", mk(1, 6'h21, 1, 2'd0, 32'h20, 6'h01, 32'h20));
        apply("r_e4", mk(1, 6'h21, 0, 2'd1, 0, 6'h01, 32'h2101));
        apply("r_e5", mk(1, 6'h21, 0, 2'd1, 0, 6'h01, 32'h2101));
        apply("r_e6", mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h2101));
        apply("r_e7", mk(1, 6'h01, 0, 2'd1, 0, 6'h01, 32'h0101));
        apply("r_e8", mk(1, 6'h21, 0, 2'd1, 0, 6'h01, 32'h0101));
        apply("r_e9", mk(1, 6'h21, 0, 2'd1, 0, 6'h01, 32'h2101));
        apply("r_e10", mk(1, 6'h21, 0, 2'd1, 0, 6'h21, 32'h2121));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
